// File: rtl/octavo_io_port_fifo_bank.sv
// Buffered I/O port bank for one Octavo I/O side: per port, a read FIFO (external -> core)
// and a write FIFO (core -> external), exposed to the core as Empty/Full flags.
module octavo_io_port_fifo_bank #(
   parameter int WORD_WIDTH = 36,
   parameter int PORT_COUNT = 2,
   parameter int DEPTH      = 8,
   parameter int WRITE_SKID = 6
) (
   input  logic                             clock,
   input  logic                             reset_n,
   output logic [PORT_COUNT-1:0]            io_read_EF,
   output logic [PORT_COUNT*WORD_WIDTH-1:0] io_read_data,
   input  logic [PORT_COUNT-1:0]            io_rden,
   output logic [PORT_COUNT-1:0]            io_write_EF,
   input  logic [PORT_COUNT*WORD_WIDTH-1:0] io_write_data,
   input  logic [PORT_COUNT-1:0]            io_wren,
   input  logic [PORT_COUNT*WORD_WIDTH-1:0] ext_in_data,
   input  logic [PORT_COUNT-1:0]            ext_in_valid,
   output logic [PORT_COUNT-1:0]            ext_in_ready,
   output logic [PORT_COUNT*WORD_WIDTH-1:0] ext_out_data,
   output logic [PORT_COUNT-1:0]            ext_out_valid,
   input  logic [PORT_COUNT-1:0]            ext_out_ready,
   output logic [PORT_COUNT-1:0]            err_underflow,
   output logic [PORT_COUNT-1:0]            err_overflow,
   input  logic                             err_clear
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [CW-1:0] EF_LEVEL = CW'(DEPTH - WRITE_SKID);
   localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

   // Pointers wrap explicitly so DEPTH need not be a power of two.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   for (genvar i = 0; i < PORT_COUNT; i++) begin : g_port
      logic [WORD_WIDTH-1:0] rmem [DEPTH];
      logic [WORD_WIDTH-1:0] wmem [DEPTH];
      logic [PW-1:0]         r_wr_ptr, r_rd_ptr;
      logic [PW-1:0]         w_wr_ptr, w_rd_ptr;
      logic [CW-1:0]         rcount, wcount;
      logic                  r_empty, r_full, w_empty, w_full;
      logic                  r_push, r_pop, w_push, w_pop;
      logic                  uf_set, ov_set;
      logic                  err_uf_q, err_ov_q;

      assign r_empty = (rcount == '0);
      assign r_full  = (rcount == FULL_CNT);
      assign w_empty = (wcount == '0);
      assign w_full  = (wcount == FULL_CNT);

      assign io_read_EF[i]    = ~r_empty;
      assign ext_in_ready[i]  = reset_n & ~r_full;
      assign io_write_EF[i]   = (wcount >= EF_LEVEL);
      assign ext_out_valid[i] = ~w_empty;

      assign io_read_data[i*WORD_WIDTH +: WORD_WIDTH] = rmem[r_rd_ptr];
      assign ext_out_data[i*WORD_WIDTH +: WORD_WIDTH] = wmem[w_rd_ptr];

      // Full FIFOs refuse a push even when a pop happens in the same cycle.
      assign r_push = ext_in_valid[i] & ext_in_ready[i];
      assign r_pop  = io_rden[i] & ~r_empty;
      assign w_push = io_wren[i] & ~w_full;
      assign w_pop  = ext_out_ready[i] & ~w_empty;

      assign uf_set = io_rden[i] & r_empty;
      assign ov_set = io_wren[i] & w_full;

      always_ff @(posedge clock or negedge reset_n) begin
         if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            rcount   <= '0;
         end else begin
            if (r_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (r_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            rcount <= rcount + CW'(r_push) - CW'(r_pop);
         end
      end

      always_ff @(posedge clock or negedge reset_n) begin
         if (!reset_n) begin
            w_wr_ptr <= '0;
            w_rd_ptr <= '0;
            wcount   <= '0;
         end else begin
            if (w_push) w_wr_ptr <= ptr_inc(w_wr_ptr);
            if (w_pop)  w_rd_ptr <= ptr_inc(w_rd_ptr);
            wcount <= wcount + CW'(w_push) - CW'(w_pop);
         end
      end

      // Storage carries no reset; contents are only visible behind a non-zero count.
      always_ff @(posedge clock) begin
         if (r_push) rmem[r_wr_ptr] <= ext_in_data[i*WORD_WIDTH +: WORD_WIDTH];
         if (w_push) wmem[w_wr_ptr] <= io_write_data[i*WORD_WIDTH +: WORD_WIDTH];
      end

      // A fault in the clearing cycle wins so it is never lost.
      always_ff @(posedge clock or negedge reset_n) begin
         if (!reset_n) begin
            err_uf_q <= 1'b0;
            err_ov_q <= 1'b0;
         end else begin
            err_uf_q <= uf_set | (err_uf_q & ~err_clear);
            err_ov_q <= ov_set | (err_ov_q & ~err_clear);
         end
      end

      assign err_underflow[i] = err_uf_q;
      assign err_overflow[i]  = err_ov_q;
   end

endmodule

// File: tb/tb_octavo_io_port_fifo_bank.sv
// Bench for octavo_io_port_fifo_bank: directed scenarios on a DEPTH=8 bank and a
// randomized run on a 4-port DEPTH=5 bank, both checked through expected-data queues.
module tb_octavo_io_port_fifo_bank;

   localparam int AW = 36, AP = 2, AD = 8, AS = 6;
   localparam int BW = 16, BP = 4, BD = 5, BS = 2;
   localparam int RAND_CYCLES = 10000;
   localparam int DRAIN_CYCLES = 60;

   logic clock;

   logic             a_reset_n, a_err_clear;
   logic [AP-1:0]    a_io_read_EF, a_io_rden, a_io_write_EF, a_io_wren;
   logic [AP-1:0]    a_ext_in_valid, a_ext_in_ready, a_ext_out_valid, a_ext_out_ready;
   logic [AP-1:0]    a_err_underflow, a_err_overflow;
   logic [AP*AW-1:0] a_io_read_data, a_io_write_data, a_ext_in_data, a_ext_out_data;

   logic             b_reset_n, b_err_clear;
   logic [BP-1:0]    b_io_read_EF, b_io_rden, b_io_write_EF, b_io_wren;
   logic [BP-1:0]    b_ext_in_valid, b_ext_in_ready, b_ext_out_valid, b_ext_out_ready;
   logic [BP-1:0]    b_err_underflow, b_err_overflow;
   logic [BP*BW-1:0] b_io_read_data, b_io_write_data, b_ext_in_data, b_ext_out_data;

   int errors = 0;
   int checks = 0;

   logic [AW-1:0] a_rq [AP][$];
   logic [AW-1:0] a_wq [AP][$];
   logic [BW-1:0] b_rq [BP][$];
   logic [BW-1:0] b_wq [BP][$];

   // Reference occupancy and sticky-error state for the random bank
   int      mr [BP];
   int      mw [BP];
   int      cur_r [BP];
   int      cur_w [BP];
   logic [BP-1:0] euf, eov, cur_uf, cur_ov;
   logic    b_run = 1'b0;

   octavo_io_port_fifo_bank #(.WORD_WIDTH(AW), .PORT_COUNT(AP), .DEPTH(AD), .WRITE_SKID(AS)) dut_a (
      .clock(clock), .reset_n(a_reset_n),
      .io_read_EF(a_io_read_EF), .io_read_data(a_io_read_data), .io_rden(a_io_rden),
      .io_write_EF(a_io_write_EF), .io_write_data(a_io_write_data), .io_wren(a_io_wren),
      .ext_in_data(a_ext_in_data), .ext_in_valid(a_ext_in_valid), .ext_in_ready(a_ext_in_ready),
      .ext_out_data(a_ext_out_data), .ext_out_valid(a_ext_out_valid), .ext_out_ready(a_ext_out_ready),
      .err_underflow(a_err_underflow), .err_overflow(a_err_overflow), .err_clear(a_err_clear)
   );

   octavo_io_port_fifo_bank #(.WORD_WIDTH(BW), .PORT_COUNT(BP), .DEPTH(BD), .WRITE_SKID(BS)) dut_b (
      .clock(clock), .reset_n(b_reset_n),
      .io_read_EF(b_io_read_EF), .io_read_data(b_io_read_data), .io_rden(b_io_rden),
      .io_write_EF(b_io_write_EF), .io_write_data(b_io_write_data), .io_wren(b_io_wren),
      .ext_in_data(b_ext_in_data), .ext_in_valid(b_ext_in_valid), .ext_in_ready(b_ext_in_ready),
      .ext_out_data(b_ext_out_data), .ext_out_valid(b_ext_out_valid), .ext_out_ready(b_ext_out_ready),
      .err_underflow(b_err_underflow), .err_overflow(b_err_overflow), .err_clear(b_err_clear)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic dup_fail(input string nm);
      checks++;
      errors++;
      $display("FAIL %s: DUT presented a word but no word was expected", nm);
   endtask

   // Inputs change one time unit after the falling edge; outputs then reflect the last rising edge.
   task automatic cyc();
      @(negedge clock);
      #1;
   endtask

   // Monitor for bank A: pops expected data whenever a transfer is presented.
   initial begin
      forever begin
         @(negedge clock);
         #3;
         for (int i = 0; i < AP; i++) begin
            if (a_io_rden[i] && a_io_read_EF[i]) begin
               if (a_rq[i].size() == 0) dup_fail($sformatf("a_rd_data%0d", i));
               else check($sformatf("a_rd_data%0d", i), 64'(a_io_read_data[i*AW +: AW]), 64'(a_rq[i].pop_front()));
            end
            if (a_ext_out_valid[i] && a_ext_out_ready[i]) begin
               if (a_wq[i].size() == 0) dup_fail($sformatf("a_out_data%0d", i));
               else check($sformatf("a_out_data%0d", i), 64'(a_ext_out_data[i*AW +: AW]), 64'(a_wq[i].pop_front()));
            end
         end
      end
   end

   // Monitor for bank B: flags against reference occupancy, data against queues.
   initial begin
      forever begin
         @(negedge clock);
         #3;
         if (b_run) begin
            for (int i = 0; i < BP; i++) begin
               check($sformatf("b_rd_ef%0d", i), 64'(b_io_read_EF[i]), 64'(cur_r[i] != 0));
               check($sformatf("b_in_rdy%0d", i), 64'(b_ext_in_ready[i]), 64'(cur_r[i] != BD));
               check($sformatf("b_wr_ef%0d", i), 64'(b_io_write_EF[i]), 64'(cur_w[i] >= BD - BS));
               check($sformatf("b_out_vld%0d", i), 64'(b_ext_out_valid[i]), 64'(cur_w[i] != 0));
               check($sformatf("b_uf%0d", i), 64'(b_err_underflow[i]), 64'(cur_uf[i]));
               check($sformatf("b_ov%0d", i), 64'(b_err_overflow[i]), 64'(cur_ov[i]));
               if (b_io_rden[i] && b_io_read_EF[i]) begin
                  if (b_rq[i].size() == 0) dup_fail($sformatf("b_rd_data%0d", i));
                  else check($sformatf("b_rd_data%0d", i), 64'(b_io_read_data[i*BW +: BW]), 64'(b_rq[i].pop_front()));
               end
               if (b_ext_out_valid[i] && b_ext_out_ready[i]) begin
                  if (b_wq[i].size() == 0) dup_fail($sformatf("b_out_data%0d", i));
                  else check($sformatf("b_out_data%0d", i), 64'(b_ext_out_data[i*BW +: BW]), 64'(b_wq[i].pop_front()));
               end
            end
         end
      end
   end

   task automatic a_idle();
      a_io_rden = '0; a_io_wren = '0; a_ext_in_valid = '0; a_ext_out_ready = '0; a_err_clear = 1'b0;
   endtask

   task automatic directed();
      a_reset_n = 1'b0; a_idle();
      a_io_write_data = '0; a_ext_in_data = '0;
      cyc(); cyc();
      check("a_rst_rd_ef", 64'(a_io_read_EF), 64'(0));
      check("a_rst_wr_ef", 64'(a_io_write_EF), 64'(0));
      check("a_rst_out_vld", 64'(a_ext_out_valid), 64'(0));
      check("a_rst_in_rdy", 64'(a_ext_in_ready), 64'(0));
      check("a_rst_err", 64'({a_err_underflow, a_err_overflow}), 64'(0));
      a_reset_n = 1'b1;
      cyc();
      check("a_rel_in_rdy", 64'(a_ext_in_ready), 64'(2'b11));

      // Read path: fill port 0 then drain in order
      for (int k = 0; k < AD; k++) begin
         a_ext_in_valid = 2'b01;
         a_ext_in_data[AW-1:0] = AW'(32'h11 + k);
         a_rq[0].push_back(AW'(32'h11 + k));
         cyc();
         if (k == AD - 2) check("a_in_rdy_7", 64'(a_ext_in_ready[0]), 64'(1));
      end
      a_ext_in_valid = '0;
      check("a_in_rdy_full", 64'(a_ext_in_ready[0]), 64'(0));
      check("a_rd_ef_full", 64'(a_io_read_EF[0]), 64'(1));
      a_io_rden = 2'b01;
      repeat (AD) cyc();
      a_io_rden = '0;
      check("a_rd_ef_drained", 64'(a_io_read_EF[0]), 64'(0));
      check("a_rd_q_drained", 64'(a_rq[0].size()), 64'(0));

      // Write skid: EF after two writes, six more accepted, ninth dropped
      for (int k = 0; k < AD; k++) begin
         a_io_wren = 2'b01;
         a_io_write_data[AW-1:0] = AW'(32'hA0 + k);
         a_wq[0].push_back(AW'(32'hA0 + k));
         cyc();
         if (k == 0) check("a_wr_ef_1", 64'(a_io_write_EF[0]), 64'(0));
         if (k == 1) check("a_wr_ef_2", 64'(a_io_write_EF[0]), 64'(1));
      end
      check("a_ov_before", 64'(a_err_overflow), 64'(0));
      a_io_write_data[AW-1:0] = AW'(32'hFF);
      cyc();
      a_io_wren = '0;
      check("a_ov_after", 64'(a_err_overflow), 64'(2'b01));
      a_ext_out_ready = 2'b01;
      repeat (AD) cyc();
      a_ext_out_ready = '0;
      check("a_out_vld_drained", 64'(a_ext_out_valid), 64'(0));
      check("a_wr_ef_drained", 64'(a_io_write_EF), 64'(0));
      check("a_wr_q_drained", 64'(a_wq[0].size()), 64'(0));

      // Simultaneous push and pop at count 3
      a_ext_in_valid = 2'b01;
      for (int k = 0; k < 3; k++) begin
         a_ext_in_data[AW-1:0] = AW'(32'h21 + k);
         a_rq[0].push_back(AW'(32'h21 + k));
         cyc();
      end
      a_ext_in_data[AW-1:0] = AW'(32'h24);
      a_rq[0].push_back(AW'(32'h24));
      a_io_rden = 2'b01;
      cyc();
      a_ext_in_valid = '0;
      repeat (3) cyc();
      a_io_rden = '0;
      check("a_cnt3_ef", 64'(a_io_read_EF[0]), 64'(0));
      check("a_cnt3_q", 64'(a_rq[0].size()), 64'(0));

      // Full plus pop: push refused that cycle, taken the next
      a_ext_in_valid = 2'b01;
      for (int k = 0; k < AD; k++) begin
         a_ext_in_data[AW-1:0] = AW'(32'h31 + k);
         a_rq[0].push_back(AW'(32'h31 + k));
         cyc();
      end
      a_ext_in_data[AW-1:0] = AW'(32'h39);
      a_io_rden = 2'b01;
      check("a_fullpop_rdy", 64'(a_ext_in_ready[0]), 64'(0));
      cyc();
      a_io_rden = '0;
      check("a_fullpop_rdy_next", 64'(a_ext_in_ready[0]), 64'(1));
      a_rq[0].push_back(AW'(32'h39));
      cyc();
      a_ext_in_valid = '0;
      check("a_refull_rdy", 64'(a_ext_in_ready[0]), 64'(0));
      a_io_rden = 2'b01;
      repeat (AD) cyc();
      a_io_rden = '0;
      check("a_fullpop_ef", 64'(a_io_read_EF[0]), 64'(0));
      check("a_fullpop_q", 64'(a_rq[0].size()), 64'(0));

      // Sticky errors and clear priority
      a_err_clear = 1'b1;
      cyc();
      a_err_clear = 1'b0;
      check("a_err_cleared", 64'({a_err_underflow, a_err_overflow}), 64'(0));
      a_io_rden = 2'b10;
      cyc();
      a_io_rden = '0;
      check("a_uf_port1", 64'(a_err_underflow), 64'(2'b10));
      a_err_clear = 1'b1;
      a_io_rden = 2'b10;
      cyc();
      a_io_rden = '0;
      check("a_uf_set_wins", 64'(a_err_underflow), 64'(2'b10));
      cyc();
      a_err_clear = 1'b0;
      check("a_uf_clear", 64'(a_err_underflow), 64'(0));

      // Reset mid-stream discards buffered data
      a_ext_in_valid = 2'b01;
      a_io_wren = 2'b10;
      a_io_rden = 2'b10;
      repeat (2) cyc();
      a_idle();
      check("a_mid_rd_ef", 64'(a_io_read_EF), 64'(2'b01));
      check("a_mid_out_vld", 64'(a_ext_out_valid), 64'(2'b10));
      check("a_mid_uf", 64'(a_err_underflow), 64'(2'b10));
      a_reset_n = 1'b0;
      #1;
      check("a_mid_rst_rd_ef", 64'(a_io_read_EF), 64'(0));
      check("a_mid_rst_wr_ef", 64'(a_io_write_EF), 64'(0));
      check("a_mid_rst_out_vld", 64'(a_ext_out_valid), 64'(0));
      check("a_mid_rst_in_rdy", 64'(a_ext_in_ready), 64'(0));
      check("a_mid_rst_err", 64'({a_err_underflow, a_err_overflow}), 64'(0));
      cyc();
      a_reset_n = 1'b1;
      cyc();
      check("a_post_rdy", 64'(a_ext_in_ready), 64'(2'b11));
      check("a_post_ef", 64'({a_io_read_EF, a_ext_out_valid}), 64'(0));
   endtask

   task automatic random_run();
      int pin, pout, win, wout;
      logic clr, v, r, wr, rdy;
      logic [BW-1:0] din, dw;
      b_reset_n = 1'b0;
      b_io_rden = '0; b_io_wren = '0; b_ext_in_valid = '0; b_ext_out_ready = '0; b_err_clear = 1'b0;
      b_io_write_data = '0; b_ext_in_data = '0;
      for (int i = 0; i < BP; i++) begin mr[i] = 0; mw[i] = 0; end
      euf = '0; eov = '0;
      cyc(); cyc();
      b_reset_n = 1'b1;
      cyc();
      b_run = 1'b1;
      for (int c = 0; c < RAND_CYCLES + DRAIN_CYCLES; c++) begin
         case ((c / 700) % 3)
            0: begin pin = 80; pout = 30; win = 30; wout = 80; end
            1: begin pin = 30; pout = 80; win = 85; wout = 25; end
            default: begin pin = 50; pout = 50; win = 50; wout = 50; end
         endcase
         if (c >= RAND_CYCLES) begin pin = 0; pout = 100; win = 0; wout = 100; end
         clr = (c < RAND_CYCLES) && ($urandom_range(99) < 3);
         b_err_clear = clr;
         cur_uf = euf;
         cur_ov = eov;
         for (int i = 0; i < BP; i++) begin
            v   = $urandom_range(99) < pin;
            r   = $urandom_range(99) < pout;
            wr  = $urandom_range(99) < win;
            rdy = $urandom_range(99) < wout;
            din = BW'($urandom);
            dw  = BW'($urandom);
            b_ext_in_valid[i] = v;  b_ext_in_data[i*BW +: BW] = din;
            b_io_rden[i] = r;
            b_io_wren[i] = wr;      b_io_write_data[i*BW +: BW] = dw;
            b_ext_out_ready[i] = rdy;
            cur_r[i] = mr[i];
            cur_w[i] = mw[i];
            if (v && mr[i] != BD) begin b_rq[i].push_back(din); mr[i]++; end
            if (r && cur_r[i] != 0) mr[i]--;
            if (wr && mw[i] != BD) begin b_wq[i].push_back(dw); mw[i]++; end
            if (rdy && cur_w[i] != 0) mw[i]--;
            euf[i] = (r && cur_r[i] == 0) || (euf[i] && !clr);
            eov[i] = (wr && cur_w[i] == BD) || (eov[i] && !clr);
         end
         cyc();
      end
      b_run = 1'b0;
      b_io_rden = '0; b_io_wren = '0; b_ext_in_valid = '0; b_ext_out_ready = '0; b_err_clear = 1'b0;
      for (int i = 0; i < BP; i++) begin
         check($sformatf("b_rd_lost%0d", i), 64'(b_rq[i].size()), 64'(0));
         check($sformatf("b_out_lost%0d", i), 64'(b_wq[i].size()), 64'(0));
      end
   endtask

   initial begin
      b_reset_n = 1'b0;
      b_io_rden = '0; b_io_wren = '0; b_ext_in_valid = '0; b_ext_out_ready = '0; b_err_clear = 1'b0;
      b_io_write_data = '0; b_ext_in_data = '0;
      directed();
      random_run();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
